lfsr_gen: RTL and testbench

- Parametrised successor to the team's fixed 4-bit LFSR.
- Configurable width and feedback polynomial; run-time selectable Fibonacci or Galois form.
- Adds advance enable, seed load with all-zero protection, and period tracking (step counter, wrap pulse, measured period).
- Used as a pseudo-random source / test-pattern generator feeding datapath blocks and benches.

---
 rtl/lfsr_pkg.sv | 65 ++++++
 rtl/lfsr_next.sv | 43 ++++
 rtl/lfsr_gen.sv | 144 ++++++++++++++
 tb/tb_lfsr_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared types and constants for the parametrised LFSR
//                generator. Provides the feedback-form enum, a table of
//                maximal-length tap masks for widths 3..32 and the width
//                legality check used at elaboration.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    localparam int LFSR_MIN_WIDTH = 3;
    localparam int LFSR_MAX_WIDTH = 32;

    // Bit i set means term x^(i+1) present; the leading term x^WIDTH is
    // always included as bit WIDTH-1.
    function automatic logic [31:0] lfsr_default_taps(input int width);
        logic [31:0] taps;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

    function automatic bit lfsr_width_ok(input int width);
        return (width >= LFSR_MIN_WIDTH) && (width <= LFSR_MAX_WIDTH);
    endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_next.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_next
//  Description : Combinational next-state function of the LFSR in either
//                Fibonacci (shift left, XOR of tapped bits into bit 0) or
//                Galois (shift left, MSB conditionally XORs the tap mask)
//                form.
//  Ports       : state [WIDTH-1:0]  current register contents
//                mode               feedback form (LFSR_FIB / LFSR_GAL)
//                next  [WIDTH-1:0]  successor state
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic [WIDTH-1:0] state,
    input  lfsr_mode_e       mode,
    output logic [WIDTH-1:0] next
);

    logic             fib_fb;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] gal_mask;

    always_comb begin
        fib_fb   = ^(state & TAPS);
        shifted  = {state[WIDTH-2:0], 1'b0};
        // The x^0 term of the polynomial is implicit, hence the forced 1
        // in the lowest bit of the Galois feedback mask.
        gal_mask = state[WIDTH-1] ? {TAPS[WIDTH-2:0], 1'b1} : '0;
        next     = '0;
        case (mode)
            LFSR_FIB: next = {state[WIDTH-2:0], fib_fb};
            LFSR_GAL: next = shifted ^ gal_mask;
            default:  next = {state[WIDTH-2:0], fib_fb};
        endcase
    end

endmodule : lfsr_next
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : Parametrised LFSR pattern generator with run-time
//                Fibonacci/Galois selection, advance enable, seed load with
//                all-zero protection, lockup recovery and period tracking.
//  Ports       : clk         rising-edge clock
//                reset       asynchronous active-low reset
//                en_i        advance one step this cycle
//                mode_i      0 = Fibonacci, 1 = Galois
//                load_i      load seed_i this cycle
//                seed_i      seed value for load
//                lfsr_o      current state (registered)
//                bit_o       serial output, lfsr_o[WIDTH-1]
//                step_cnt_o  advances since last load/reset/mode change/wrap
//                wrap_o      one-cycle pulse when state returns to start
//                period_o    step count latched at the last wrap
//                zero_err_o  one-cycle pulse when an all-zero state/seed was
//                            replaced by SEED
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter logic [WIDTH-1:0] SEED  = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] lfsr_o,
    output logic             bit_o,
    output logic [WIDTH-1:0] step_cnt_o,
    output logic             wrap_o,
    output logic [WIDTH-1:0] period_o,
    output logic             zero_err_o
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!lfsr_width_ok(WIDTH)) begin : g_bad_width
        $fatal(1, "lfsr_gen: WIDTH %0d outside legal range 3..32", WIDTH);
    end else begin : g_width_ok
        if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
            $fatal(1, "lfsr_gen: TAPS must include the x^WIDTH term");
        end
        if (SEED == '0) begin : g_bad_seed
            $fatal(1, "lfsr_gen: SEED must be non-zero");
        end
    end

    localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] start_q;
    lfsr_mode_e       mode_q;
    logic [WIDTH-1:0] step_cnt_q;
    logic [WIDTH-1:0] period_q;
    logic             wrap_q;
    logic             zero_err_q;

    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] load_value;
    logic             seed_is_zero;
    logic             mode_change;
    lfsr_mode_e       mode_req;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .state (state_q),
        .mode  (mode_q),
        .next  (next_state)
    );

    always_comb begin
        mode_req     = lfsr_mode_e'(mode_i);
        mode_change  = (mode_req != mode_q);
        seed_is_zero = (seed_i == '0);
        load_value   = seed_is_zero ? SEED : seed_i;
    end

    // Priority: load > lockup recovery > mode change > advance.
    // A mode change restarts period measurement from the current state,
    // since the cycle through that state differs between the two forms.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SEED;
            start_q    <= SEED;
            mode_q     <= LFSR_FIB;
            step_cnt_q <= '0;
            period_q   <= '0;
            wrap_q     <= 1'b0;
            zero_err_q <= 1'b0;
        end else begin
            wrap_q     <= 1'b0;
            zero_err_q <= 1'b0;
            if (load_i) begin
                state_q    <= load_value;
                start_q    <= load_value;
                step_cnt_q <= '0;
                zero_err_q <= seed_is_zero;
            end else if (state_q == '0) begin
                // All-zero is a fixed point of both forms; only reachable by
                // an upset, so recover to the known seed.
                state_q    <= SEED;
                start_q    <= SEED;
                step_cnt_q <= '0;
                zero_err_q <= 1'b1;
            end else if (mode_change) begin
                mode_q     <= mode_req;
                start_q    <= state_q;
                step_cnt_q <= '0;
            end else if (en_i) begin
                state_q <= next_state;
                if (next_state == start_q) begin
                    wrap_q     <= 1'b1;
                    period_q   <= step_cnt_q + STEP_ONE;
                    step_cnt_q <= '0;
                end else begin
                    step_cnt_q <= step_cnt_q + STEP_ONE;
                end
            end
        end
    end

    assign lfsr_o     = state_q;
    assign bit_o      = state_q[WIDTH-1];
    assign step_cnt_o = step_cnt_q;
    assign wrap_o     = wrap_q;
    assign period_o   = period_q;
    assign zero_err_o = zero_err_q;

endmodule : lfsr_gen
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_gen
//  Description : Directed self-checking bench for lfsr_gen: 4-bit default
//                instance (Fibonacci, Galois, loads, mode change, enable
//                gating, lockup recovery, async reset) and an 8-bit
//                maximal-length instance for full-period measurement.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_gen;

    logic       clk;
    logic       reset;
    logic       en, mode, load;
    logic [3:0] seed;
    logic [3:0] lfsr;
    logic       bitv;
    logic [3:0] step_cnt;
    logic       wrap;
    logic [3:0] period;
    logic       zero_err;

    logic       en8;
    logic       mode8, load8;
    logic [7:0] seed8;
    logic [7:0] lfsr8;
    logic       bit8;
    logic [7:0] step8;
    logic       wrap8;
    logic [7:0] period8;
    logic       zero_err8;

    int checks = 0;
    int errors = 0;

    logic [3:0] fib_seq [0:15];
    logic [3:0] gal_seq [0:15];

    lfsr_gen #(
        .WIDTH (4),
        .TAPS  (4'b1100),
        .SEED  (4'b0001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en),
        .mode_i     (mode),
        .load_i     (load),
        .seed_i     (seed),
        .lfsr_o     (lfsr),
        .bit_o      (bitv),
        .step_cnt_o (step_cnt),
        .wrap_o     (wrap),
        .period_o   (period),
        .zero_err_o (zero_err)
    );

    lfsr_gen #(
        .WIDTH (8),
        .TAPS  (8'b1011_1000),
        .SEED  (8'h01)
    ) dut8 (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en8),
        .mode_i     (mode8),
        .load_i     (load8),
        .seed_i     (seed8),
        .lfsr_o     (lfsr8),
        .bit_o      (bit8),
        .step_cnt_o (step8),
        .wrap_o     (wrap8),
        .period_o   (period8),
        .zero_err_o (zero_err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int  n8;
        bit  seen8;

        fib_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                    4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111,
                    4'b1110, 4'b1100, 4'b1000, 4'b0001};
        gal_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b1011,
                    4'b1111, 4'b0111, 4'b1110, 4'b0101, 4'b1010, 4'b1101,
                    4'b0011, 4'b0110, 4'b1100, 4'b0001};

        reset = 1'b0;
        en = 1'b0; mode = 1'b0; load = 1'b0; seed = 4'b0000;
        en8 = 1'b0; mode8 = 1'b0; load8 = 1'b0; seed8 = 8'h00;
        tick();
        tick();

        // Reset values
        check("rst_lfsr", lfsr, 4'b0001);
        check("rst_bit", bitv, 1'b0);
        check("rst_step", step_cnt, 4'd0);
        check("rst_wrap", wrap, 1'b0);
        check("rst_period", period, 4'd0);
        check("rst_zero_err", zero_err, 1'b0);
        reset = 1'b1;
        tick();
        check("idle_lfsr", lfsr, 4'b0001);

        // Fibonacci full period
        en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check($sformatf("fib_lfsr_%0d", k), lfsr, fib_seq[k]);
            check($sformatf("fib_bit_%0d", k), bitv, fib_seq[k][3]);
            check($sformatf("fib_step_%0d", k), step_cnt, (k == 15) ? 4'd0 : 4'(k));
            check($sformatf("fib_wrap_%0d", k), wrap, (k == 15) ? 1'b1 : 1'b0);
        end
        check("fib_period", period, 4'd15);

        // Galois: first cycle is the mode change, no advance
        mode = 1'b1;
        tick();
        check("gal_modechg_lfsr", lfsr, 4'b0001);
        check("gal_modechg_step", step_cnt, 4'd0);
        check("gal_modechg_wrap", wrap, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check($sformatf("gal_lfsr_%0d", k), lfsr, gal_seq[k]);
            check($sformatf("gal_step_%0d", k), step_cnt, (k == 15) ? 4'd0 : 4'(k));
            check($sformatf("gal_wrap_%0d", k), wrap, (k == 15) ? 1'b1 : 1'b0);
        end
        check("gal_period", period, 4'd15);
        en = 1'b0;

        // Zero-seed load is replaced by SEED and flagged
        tick();
        load = 1'b1; seed = 4'b0000;
        tick();
        check("zload_lfsr", lfsr, 4'b0001);
        check("zload_zero_err", zero_err, 1'b1);
        check("zload_step", step_cnt, 4'd0);
        load = 1'b0;
        tick();
        check("zload_err_clear", zero_err, 1'b0);

        // Load wins over enable
        load = 1'b1; seed = 4'b1010; en = 1'b1;
        tick();
        check("load_en_lfsr", lfsr, 4'b1010);
        check("load_en_step", step_cnt, 4'd0);
        check("load_en_zero_err", zero_err, 1'b0);
        check("load_en_wrap", wrap, 1'b0);

        // Load also wins over a pending mode change
        en = 1'b0; mode = 1'b0; seed = 4'b0001;
        tick();
        check("load_vs_mode_lfsr", lfsr, 4'b0001);
        load = 1'b0;
        tick();
        check("modechg_fib_lfsr", lfsr, 4'b0001);
        check("modechg_fib_step", step_cnt, 4'd0);

        // Enable gating 1,0,0,1 in Fibonacci
        en = 1'b1; tick();
        check("gate1_lfsr", lfsr, 4'b0010);
        check("gate1_step", step_cnt, 4'd1);
        en = 1'b0; tick();
        check("gate2_lfsr", lfsr, 4'b0010);
        check("gate2_step", step_cnt, 4'd1);
        tick();
        check("gate3_lfsr", lfsr, 4'b0010);
        check("gate3_step", step_cnt, 4'd1);
        en = 1'b1; tick();
        check("gate4_lfsr", lfsr, 4'b0100);
        check("gate4_step", step_cnt, 4'd2);
        check("gate4_wrap", wrap, 1'b0);

        // Lockup recovery from a corrupted all-zero state, enable held high
        force dut.state_q = 4'b0000;
        #1;
        release dut.state_q;
        tick();
        check("lockup_lfsr", lfsr, 4'b0001);
        check("lockup_zero_err", zero_err, 1'b1);
        check("lockup_step", step_cnt, 4'd0);

        // Advance to 1101 then assert reset between clock edges
        for (int k = 1; k <= 6; k++) begin
            tick();
        end
        check("pre_rst_lfsr", lfsr, 4'b1101);
        check("pre_rst_step", step_cnt, 4'd6);
        check("pre_rst_period", period, 4'd15);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_lfsr", lfsr, 4'b0001);
        check("async_rst_step", step_cnt, 4'd0);
        check("async_rst_period", period, 4'd0);
        check("async_rst_wrap", wrap, 1'b0);
        en = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // 8-bit maximal-length period
        tick();
        en8 = 1'b1;
        n8 = 0;
        seen8 = 1'b0;
        for (int k = 0; k < 300 && !seen8; k++) begin
            tick();
            n8++;
            check("w8_nonzero", (lfsr8 != 8'h00), 1'b1);
            if (wrap8) seen8 = 1'b1;
        end
        check("w8_wrap_seen", seen8, 1'b1);
        check("w8_advances", n8, 255);
        check("w8_period", period8, 8'd255);
        check("w8_lfsr_back", lfsr8, 8'h01);
        check("w8_step", step8, 8'd0);
        en8 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_lfsr_gen
`default_nettype wire
